// File: rtl/branch_predictor_unit_pkg.sv
// Shared encodings and counter helper for the fetch-stage branch predictor.
package branch_predictor_unit_pkg;

  // Control-flow kind, same encoding as the pipeline's jump_code.
  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_code_e;

  // Saturating step for counters up to 8 bits; callers zero-extend and truncate.
  function automatic logic [7:0] ctr_step(input logic [7:0] ctr, input logic up,
                                          input logic [7:0] max);
    if (up) return (ctr == max) ? ctr : ctr + 8'd1;
    else    return (ctr == 8'd0) ? ctr : ctr - 8'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_unit_if.sv
// Fetch lookup and execute training signals of the branch predictor.
interface branch_predictor_unit_if #(
  parameter int PC_W      = 13,
  parameter int RAS_DEPTH = 4
);
  logic [PC_W-1:0]              f_pc;
  logic                         f_pred_taken;
  logic [PC_W-1:0]              f_pred_pc;
  // e_valid is a single-cycle strobe with no back-pressure: every cycle it is
  // high, the e_* fields are consumed at that rising edge (unless flush is high).
  logic                         e_valid;
  logic [PC_W-1:0]              e_pc;
  logic [1:0]                   e_kind;
  logic                         e_taken;
  logic [PC_W-1:0]              e_target;
  logic                         e_is_call;
  logic                         e_is_ret;
  logic [PC_W-1:0]              e_link_pc;
  logic                         flush;
  logic [$clog2(RAS_DEPTH):0]   ras_count;

  modport master (
    output f_pc, e_valid, e_pc, e_kind, e_taken, e_target,
           e_is_call, e_is_ret, e_link_pc, flush,
    input  f_pred_taken, f_pred_pc, ras_count
  );

  modport slave (
    input  f_pc, e_valid, e_pc, e_kind, e_taken, e_target,
           e_is_call, e_is_ret, e_link_pc, flush,
    output f_pred_taken, f_pred_pc, ras_count
  );
endinterface

// File: rtl/branch_predictor_unit_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bpu_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 13,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr_q;   // next free slot
  logic [CNT_W-1:0] count_q;
  logic             pop_eff;

  assign pop_eff = pop && (count_q != '0);
  assign top     = mem[ptr_q - PTR_W'(1)];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (clear) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (pop_eff && !push) begin
      ptr_q   <= ptr_q - PTR_W'(1);
      count_q <= count_q - CNT_W'(1);
    end else if (push && !pop_eff) begin
      ptr_q   <= ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end
  end

  // Pop+push replaces the top in place, so pointer and count stay put.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      if (pop_eff) mem[ptr_q - PTR_W'(1)] <= push_data;
      else         mem[ptr_q]             <= push_data;
    end
  end
endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped branch target table with RAS-assisted return prediction.
module branch_predictor_unit
  import branch_predictor_unit_pkg::*;
#(
  parameter int PC_W      = 13,
  parameter int IDX_W     = 11,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  branch_predictor_unit_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};

  logic [DEPTH-1:0]    valid_q;
  logic [1:0]          kind_q   [DEPTH];
  logic                is_ret_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_q    [DEPTH];
  logic [TAG_W-1:0]    tag_q    [DEPTH];
  logic [PC_W-1:0]     target_q [DEPTH];

  logic [IDX_W-1:0]    f_idx, e_idx;
  logic [TAG_W-1:0]    f_tag, e_tag;
  logic                f_hit, f_taken, e_hit, upd_en, tbl_wr;
  logic [CTR_BITS-1:0] ctr_next;
  logic [PC_W-1:0]     ras_top;

  assign f_idx = bus.f_pc[IDX_W-1:0];
  assign f_tag = bus.f_pc[PC_W-1:IDX_W];
  assign e_idx = bus.e_pc[IDX_W-1:0];
  assign e_tag = bus.e_pc[PC_W-1:IDX_W];

  always_comb begin
    f_hit            = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken          = f_hit && ((kind_q[f_idx] == KIND_JAL) || (kind_q[f_idx] == KIND_JALR) ||
                                 ((kind_q[f_idx] == KIND_BR) && ctr_q[f_idx][CTR_BITS-1]));
    bus.f_pred_taken = f_taken;
    bus.f_pred_pc    = bus.f_pc + PC_W'(1);
    if (f_taken && is_ret_q[f_idx] && (bus.ras_count != '0)) bus.f_pred_pc = ras_top;
    else if (f_taken)                                        bus.f_pred_pc = target_q[f_idx];
  end

  // Misses only allocate on taken results; a flush drops the update entirely.
  always_comb begin
    e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    upd_en   = bus.e_valid && (bus.e_kind != KIND_NONE) && !bus.flush;
    tbl_wr   = upd_en && (e_hit || bus.e_taken);
    ctr_next = CTR_MAX;
    if (bus.e_kind == KIND_BR)
      ctr_next = e_hit ? CTR_BITS'(ctr_step(8'(ctr_q[e_idx]), bus.e_taken, 8'(CTR_MAX)))
                       : CTR_INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid_q <= '0;
    else if (bus.flush) valid_q <= '0;
    else if (tbl_wr)    valid_q[e_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      kind_q[e_idx]   <= bus.e_kind;
      is_ret_q[e_idx] <= bus.e_is_ret;
      ctr_q[e_idx]    <= ctr_next;
      tag_q[e_idx]    <= e_tag;
      if (bus.e_taken) target_q[e_idx] <= bus.e_target;
    end
  end

  bpu_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.flush),
    .push      (bus.e_valid && bus.e_is_call && !bus.flush),
    .pop       (bus.e_valid && bus.e_is_ret && !bus.flush),
    .push_data (bus.e_link_pc),
    .top       (ras_top),
    .count     (bus.ras_count)
  );
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed and random checks of branch_predictor_unit against a table/queue model.
module tb_branch_predictor_unit;
  import branch_predictor_unit_pkg::*;

  localparam int PC_W = 13;
  localparam int IDX_W = 11;
  localparam int RAS_DEPTH = 4;
  localparam int NENT = 1 << IDX_W;
  localparam int PC_MOD = 1 << PC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor_unit_if #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  branch_predictor_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_BITS(2), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: entries remember the full PC that owns them.
  bit m_valid [NENT];
  int m_owner [NENT];
  int m_kind  [NENT];
  bit m_ret   [NENT];
  int m_ctr   [NENT];
  int m_tgt   [NENT];
  int m_ras[$];

  bit d_valid, d_taken, d_call, d_ret, d_flush;
  int d_kind, d_pc, d_target;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_tick();
    int idx;
    bit hit;
    idx = d_pc % NENT;
    hit = m_valid[idx] && (m_owner[idx] == d_pc);
    if (d_flush) begin
      model_reset();
      return;
    end
    if (!d_valid) return;
    if (d_kind != 0) begin
      if (hit) begin
        if (d_kind == 1) m_ctr[idx] = d_taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                              : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        else m_ctr[idx] = 3;
        if (d_taken) m_tgt[idx] = d_target;
        m_kind[idx] = d_kind;
        m_ret[idx]  = d_ret;
      end else if (d_taken) begin
        m_valid[idx] = 1'b1;
        m_owner[idx] = d_pc;
        m_kind[idx]  = d_kind;
        m_ret[idx]   = d_ret;
        m_ctr[idx]   = (d_kind == 1) ? 2 : 3;
        m_tgt[idx]   = d_target;
      end
    end
    if (d_ret && m_ras.size() > 0) void'(m_ras.pop_back());
    if (d_call) begin
      m_ras.push_back((d_pc + 1) % PC_MOD);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end
  endfunction

  task automatic drive(input bit v, input int kind, input int pc, input bit taken,
                       input int target, input bit call, input bit ret, input bit fl);
    d_valid = v; d_kind = kind; d_pc = pc; d_taken = taken;
    d_target = target; d_call = call; d_ret = ret; d_flush = fl;
    bus.e_valid   = v;
    bus.e_kind    = kind[1:0];
    bus.e_pc      = pc[PC_W-1:0];
    bus.e_taken   = taken;
    bus.e_target  = target[PC_W-1:0];
    bus.e_is_call = call;
    bus.e_is_ret  = ret;
    bus.e_link_pc = PC_W'((pc + 1) % PC_MOD);
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input int kind, input int pc, input bit taken, input int target,
                      input bit call, input bit ret);
    drive(1'b1, kind, pc, taken, target, call, ret, 1'b0);
    tick();
  endtask

  task automatic look_exp(input string tag, input int pc, input bit exp_t, input int exp_pc);
    bus.f_pc = pc[PC_W-1:0];
    #1;
    chk({tag, "_taken"}, 32'(bus.f_pred_taken), 32'(exp_t));
    chk({tag, "_pc"}, 32'(bus.f_pred_pc), 32'(exp_pc));
  endtask

  task automatic look_model(input string tag, input int pc);
    int idx, pred;
    bit hit, taken;
    idx   = pc % NENT;
    hit   = m_valid[idx] && (m_owner[idx] == pc);
    taken = hit && (m_kind[idx] != 1 || m_ctr[idx] >= 2);
    if (taken && m_ret[idx] && m_ras.size() > 0) pred = m_ras[$];
    else if (taken)                              pred = m_tgt[idx];
    else                                         pred = (pc + 1) % PC_MOD;
    look_exp(tag, pc, taken, pred);
  endtask

  task automatic chk_count(input string tag, input int exp);
    chk(tag, 32'(bus.ras_count), 32'(exp));
  endtask

  int pool [8] = '{13'h0040, 13'h0840, 13'h0200, 13'h0010, 13'h1FFF, 13'h07FF, 13'h0FFF, 13'h0123};

  initial begin
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    bus.f_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    look_exp("reset", 13'h0100, 1'b0, 13'h0101);
    chk_count("reset_ras", 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Conditional branch training and counter saturation
    send(KIND_BR, 13'h0040, 1'b1, 13'h0030, 1'b0, 1'b0);
    look_exp("br_alloc", 13'h0040, 1'b1, 13'h0030);
    repeat (2) send(KIND_BR, 13'h0040, 1'b0, 13'h0000, 1'b0, 1'b0);
    look_exp("br_nt2", 13'h0040, 1'b0, 13'h0041);
    repeat (4) send(KIND_BR, 13'h0040, 1'b1, 13'h0030, 1'b0, 1'b0);
    look_exp("br_t4", 13'h0040, 1'b1, 13'h0030);
    send(KIND_BR, 13'h0040, 1'b0, 13'h0000, 1'b0, 1'b0);
    look_exp("br_sat_nt1", 13'h0040, 1'b1, 13'h0030);
    send(KIND_BR, 13'h0040, 1'b0, 13'h0000, 1'b0, 1'b0);
    look_exp("br_sat_nt2", 13'h0040, 1'b0, 13'h0041);

    // Aliasing: same index, different tag
    send(KIND_BR, 13'h0040, 1'b1, 13'h0030, 1'b0, 1'b0);
    send(KIND_BR, 13'h0840, 1'b1, 13'h0123, 1'b0, 1'b0);
    look_exp("alias_old", 13'h0040, 1'b0, 13'h0041);
    look_exp("alias_new", 13'h0840, 1'b1, 13'h0123);

    // Asynchronous reset mid-run clears the entry without waiting for an edge
    rst_n = 1'b0;
    look_exp("async_rst", 13'h0840, 1'b0, 13'h0841);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Call/return through the RAS
    send(KIND_JALR, 13'h0200, 1'b1, 13'h0005, 1'b0, 1'b1);
    look_exp("ret_empty_ras", 13'h0200, 1'b1, 13'h0005);
    send(KIND_JAL, 13'h0010, 1'b1, 13'h0080, 1'b1, 1'b0);
    chk_count("call_ras", 1);
    drive(1'b1, KIND_JALR, 13'h0200, 1'b1, 13'h0005, 1'b0, 1'b1, 1'b0);
    look_exp("ret_pre_pop", 13'h0200, 1'b1, 13'h0011);
    tick();
    chk_count("ret_post_pop", 0);
    look_exp("ret_fallback", 13'h0200, 1'b1, 13'h0005);

    // RAS overflow and underflow
    for (int i = 1; i <= 5; i++) send(KIND_JAL, i - 1, 1'b1, 13'h0400, 1'b1, 1'b0);
    chk_count("ras_full", RAS_DEPTH);
    for (int i = 5; i >= 2; i--) begin
      drive(1'b1, KIND_JALR, 13'h0200, 1'b1, 13'h0005, 1'b0, 1'b1, 1'b0);
      look_exp($sformatf("ras_pop%0d", i), 13'h0200, 1'b1, i);
      tick();
    end
    chk_count("ras_empty", 0);
    send(KIND_JALR, 13'h0200, 1'b1, 13'h0005, 1'b0, 1'b1);
    chk_count("ras_underflow", 0);

    // Flush beats a same-cycle update; old contents visible until the edge
    send(KIND_BR, 13'h0040, 1'b1, 13'h0030, 1'b0, 1'b0);
    send(KIND_JAL, 13'h0010, 1'b1, 13'h0080, 1'b1, 1'b0);
    drive(1'b1, KIND_BR, 13'h0040, 1'b1, 13'h0077, 1'b1, 1'b0, 1'b1);
    look_exp("flush_cycle", 13'h0040, 1'b1, 13'h0030);
    tick();
    look_exp("flush_br", 13'h0040, 1'b0, 13'h0041);
    look_exp("flush_ret", 13'h0200, 1'b0, 13'h0201);
    chk_count("flush_ras", 0);
    look_exp("wrap", 13'h1FFF, 1'b0, 13'h0000);

    // Random traffic over a small aliasing PC pool
    for (int n = 0; n < 400; n++) begin
      int kind;
      bit taken, call, ret;
      kind  = $urandom_range(0, 3);
      taken = (kind >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      call  = (kind >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      ret   = (kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(1'($urandom_range(0, 7) != 0), kind, pool[$urandom_range(0, 7)], taken,
            $urandom_range(0, PC_MOD - 1), call, ret, 1'($urandom_range(0, 31) == 0));
      look_model("rand_pred", pool[$urandom_range(0, 7)]);
      tick();
      chk_count("rand_ras", m_ras.size());
    end
    foreach (pool[i]) look_model("final_pred", pool[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Fetch-stage branch predictor for the RV32I pipeline, parametrised in PC width, table depth and counter width.
- Holds a direct-mapped branch target table and a return-address stack.
- Gives a same-cycle next-PC prediction for the fetch PC.
- Trains from resolved control-flow results sent by the execute stage.

Parameters:
- PC_W, 13: word-address PC width; increment is +1.
- IDX_W, 11: index bits; table holds 2^IDX_W entries; tag = PC[PC_W-1:IDX_W]; requires IDX_W < PC_W.
- CTR_BITS, 2: saturating-counter width, at least 2.
- RAS_DEPTH, 4: return stack entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- f_pc  in  PC_W  PC being fetched.
- f_pred_taken  out  1  prediction says taken.
- f_pred_pc  out  PC_W  predicted next PC.
- e_valid  in  1  update strobe from execute.
- e_pc  in  PC_W  PC of the resolved instruction.
- e_kind  in  2  00 none, 01 conditional branch, 10 jal, 11 jalr.
- e_taken  in  1  resolved direction; 1 for jal/jalr.
- e_target  in  PC_W  resolved jump target.
- e_is_call  in  1  jal/jalr with rd = x1 or x5.
- e_is_ret  in  1  jalr with rs1 = x1 or x5 and rd = x0.
- e_link_pc  in  PC_W  return address (e_pc + 1).
- flush  in  1  synchronous clear of all table valid bits and the RAS.
- ras_count  out  clog2(RAS_DEPTH)+1  current RAS occupancy.

Behaviour:
- Entry fields: valid, kind[1:0], is_ret, ctr[CTR_BITS-1:0], tag, target[PC_W-1:0].
- Reset (async, rst_n low):
  - all valid bits 0; RAS pointer 0; ras_count 0.
  - With all entries invalid, f_pred_taken = 0 and f_pred_pc = f_pc + 1.
  - Other entry fields need no reset.
- Lookup (combinational, zero latency):
  - hit = valid & (tag == f_pc upper bits).
  - taken = hit & (kind is 10 or 11, or (kind 01 & ctr MSB = 1)).
  - f_pred_pc:
    - if taken & is_ret & ras_count > 0: RAS top;
    - else if taken: stored target;
    - else f_pc + 1, wrapping modulo 2^PC_W.
- Read during update: same-cycle update to the index being read is NOT bypassed; lookup returns the pre-edge contents.
- Update at posedge when e_valid & e_kind != 00:
  - Hit:
    - branch: ctr saturating +1 if taken (clamps at max), -1 if not taken (clamps at 0).
    - jal/jalr: ctr set to max.
    - target overwritten only when e_taken.
    - kind and is_ret always overwritten.
  - Miss:
    - allocate only when e_taken, overwriting any previous occupant.
    - Branch ctr initialised to 2^(CTR_BITS-1) (weakly taken); jal/jalr ctr = max.
    - Not-taken miss leaves the table unchanged.
- RAS updates at the same edge, only when e_valid:
  - Pop if e_is_ret and count > 0; pop with count = 0 is ignored.
  - Then push e_link_pc if e_is_call.
  - Both set: top replaced, count unchanged.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
- flush:
  - Has priority over any same-cycle update; the update is dropped.
  - Takes effect at the next edge.
  - Lookups in the flush cycle use the old contents.
- e_valid low: no state change regardless of other inputs.

Decomposition:
- Shared package holds:
  - kind encodings: KIND_NONE, KIND_BR, KIND_JAL, KIND_JALR (same encoding as the existing jump_code);
  - branch_code encodings;
  - function for saturating counter increment/decrement.
- One sub-module: bpu_ras (circular return stack with push/pop/count).
- Table storage and lookup/update logic live in branch_predictor_unit.

Test Plan:
- Reset, then f_pc=0x0100 -> f_pred_taken=0, f_pred_pc=0x0101; rst_n asserted mid-run clears a trained entry immediately.
- Branch at e_pc=0x0040, taken, target 0x0030 -> next cycle f_pc=0x0040 gives taken, 0x0030; then two not-taken updates -> not taken, 0x0041; four taken updates -> ctr stays at 3 (saturation).
- Alias: train 0x0040 taken, then taken branch at 0x0840 (same index, different tag) -> 0x0040 misses (pred 0x0041), 0x0840 hits.
- Call/return: jal call at 0x0010 (link 0x0011), then ret jalr at 0x0200 (stored target 0x0005) -> before the pop, f_pc=0x0200 predicts 0x0011; after the pop edge ras_count=0 and the prediction falls back to 0x0005.
- RAS overflow, RAS_DEPTH=4: push links 1..5 -> count=4; pops return 5,4,3,2; fifth pop ignored, count stays 0.
- flush together with an e_valid taken update to 0x0040 -> update dropped, all lookups miss afterwards, ras_count=0; f_pc=0x1FFF with no entry -> f_pred_pc=0x0000 (wrap).
